// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// opcodes, ALU operations, immediate formats and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_TRAP
  } state_t;

  // What the ALU decoder should do in the current state.
  typedef enum logic [1:0] {
    ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_R, ALU_CLS_I
  } alu_cls_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_RDATA   = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: fixed ADD/SUB for sequencing states, funct3/funct7
// decode for register and immediate arithmetic.
import mc_pkg::*;

module mc_alu_dec #(
  parameter int ALU_CTRL_W = 4
) (
  input  alu_cls_t              cls,
  input  logic [2:0]            funct3,
  input  logic                  funct7_b5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [3:0] op;

  always_comb begin
    op = ALU_ADD;
    case (cls)
      ALU_CLS_SUB: op = ALU_SUB;
      ALU_CLS_R, ALU_CLS_I: begin
        case (funct3)
          3'b000:  op = (cls == ALU_CLS_R && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(op);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller for an RV32I subset: fetch, decode and per-class
// memory / execute / writeback sequencing with a sticky illegal-opcode trap.
//   state      | meaning
//   FETCH      | read instruction at PC, PC+4 -> PC
//   DECODE     | compute branch/jump target into ALU_out
//   MEMADR     | compute load/store address
//   MEMREAD    | wait for load data
//   MEMWB      | write load data to rd
//   MEMWRITE   | store, held until mem_ready
//   EXEC_R/I   | register / immediate arithmetic
//   ALUWB      | write ALU_out to rd
//   BRANCH     | compare, redirect PC if taken
//   JAL / LUI  | jump target to PC / immediate through ALU
//   TRAP       | unsupported instruction, left only by reset
import mc_pkg::*;

module multicycle_ctrl #(
  parameter int MEM_WAIT   = 1,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op_code,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  pc_w,
  output logic                  adr_src,
  output logic                  mem_w,
  output logic                  ir_w,
  output logic                  reg_w,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  retire,
  output logic                  illegal
);

  if (ALU_CTRL_W < 4) begin : g_bad_alu_ctrl_w
    $error("multicycle_ctrl: ALU_CTRL_W must be at least 4");
  end

  state_t   state_q, state_d;
  alu_cls_t alu_cls;
  logic     mem_rdy, taken;
  logic     pc_w_s, ir_w_s, mem_w_s, reg_w_s, retire_s;
  logic     funct7_unused;

  assign mem_rdy       = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign funct7_unused = &{1'b0, funct7[6], funct7[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op_code)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op_code == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH:        state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL, S_LUI:  state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_w_s = 1'b0; ir_w_s = 1'b0; mem_w_s = 1'b0; reg_w_s = 1'b0; retire_s = 1'b0;
    adr_src = 1'b0; result_src = RES_ALU_OUT; alu_src_a = SRCA_PC; alu_src_b = SRCB_RS2;
    alu_cls = ALU_CLS_ADD;
    imm_src = imm_sel(op_code);
    case (state_q)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR; result_src = RES_ALU;
        ir_w_s = mem_rdy; pc_w_s = mem_rdy;
      end
      S_DECODE:   begin alu_src_a = SRCA_OLD_PC; alu_src_b = SRCB_IMM; end
      S_MEMADR:   begin alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM; end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    begin result_src = RES_RDATA; reg_w_s = 1'b1; retire_s = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_w_s = 1'b1; retire_s = mem_rdy; end
      S_EXEC_R:   begin alu_src_a = SRCA_RS1; alu_cls = ALU_CLS_R; end
      S_EXEC_I:   begin alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM; alu_cls = ALU_CLS_I; end
      S_ALUWB:    begin reg_w_s = 1'b1; retire_s = 1'b1; end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1; alu_cls = ALU_CLS_SUB;
        pc_w_s = taken; retire_s = 1'b1;
      end
      S_JAL:      begin alu_src_a = SRCA_OLD_PC; alu_src_b = SRCB_FOUR; pc_w_s = 1'b1; end
      S_LUI:      begin alu_src_a = SRCA_ZERO; alu_src_b = SRCB_IMM; end
      default:    imm_src = IMM_I;
    endcase
  end

  mc_alu_dec #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .cls         (alu_cls),
    .funct3      (funct3),
    .funct7_b5   (funct7[5]),
    .alu_control (alu_control)
  );

  // Write enables are held low for the whole reset assertion, not just from the next edge.
  assign pc_w    = pc_w_s   & rst_n;
  assign ir_w    = ir_w_s   & rst_n;
  assign mem_w   = mem_w_s  & rst_n;
  assign reg_w   = reg_w_s  & rst_n;
  assign retire  = retire_s & rst_n;
  assign illegal = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expectations built from instruction-level
// timing rules (phase list + stall counts) and compared against the DUT.
module tb_multicycle_ctrl;

  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_LUI = 6;

  typedef struct {
    logic        mr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        z, l, lu;
    logic [19:0] exp;
  } cyc_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op_code = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;

  logic pc_w, adr_src, mem_w, ir_w, reg_w, retire, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic pc_w2, adr_src2, mem_w2, ir_w2, reg_w2, retire2, illegal2;
  logic [1:0] result_src2, alu_src_a2, alu_src_b2;
  logic [2:0] imm_src2;
  logic [3:0] alu_control2;

  logic [19:0] obs_vec, obs2_vec;
  int checks = 0, passes = 0;
  cyc_t exp_q[$];
  logic [6:0] opc_tab [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                              7'b1100011, 7'b1101111, 7'b0110111};
  logic [2:0] br_tab [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .pc_w(pc_w), .adr_src(adr_src), .mem_w(mem_w), .ir_w(ir_w), .reg_w(reg_w),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .retire(retire), .illegal(illegal)
  );

  multicycle_ctrl #(.MEM_WAIT(0)) dut_nowait (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(1'b0),
    .pc_w(pc_w2), .adr_src(adr_src2), .mem_w(mem_w2), .ir_w(ir_w2), .reg_w(reg_w2),
    .result_src(result_src2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
    .imm_src(imm_src2), .alu_control(alu_control2), .retire(retire2), .illegal(illegal2)
  );

  // [19]pc_w [18]adr_src [17]mem_w [16]ir_w [15]reg_w [14:13]result_src
  // [12:11]src_a [10:9]src_b [8:6]imm_src [5:2]alu_control [1]retire [0]illegal
  assign obs_vec  = {pc_w, adr_src, mem_w, ir_w, reg_w, result_src, alu_src_a, alu_src_b,
                     imm_src, alu_control, retire, illegal};
  assign obs2_vec = {pc_w2, adr_src2, mem_w2, ir_w2, reg_w2, result_src2, alu_src_a2,
                     alu_src_b2, imm_src2, alu_control2, retire2, illegal2};

  function automatic logic [19:0] pk(input logic pc, adr, mw, iw, rw, input logic [1:0] rs, a, b,
                                     input logic [2:0] im, input logic [3:0] alu,
                                     input logic ret, ill);
    return {pc, adr, mw, iw, rw, rs, a, b, im, alu, ret, ill};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == 7'b0100011) return 3'b001;
    if (op == 7'b1100011) return 3'b010;
    if (op == 7'b1101111) return 3'b011;
    if (op == 7'b0110111) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [3:0] alu_exp(input logic is_r, input logic [2:0] f3, input logic b5);
    case (f3)
      3'd0: return (is_r && b5) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return b5 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic z, l, lu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return lu;
      default: return !lu;
    endcase
  endfunction

  function automatic cyc_t mkc(input cyc_t base, input logic mr, input logic [19:0] e);
    cyc_t c = base;
    c.mr = mr;
    c.exp = e;
    return c;
  endfunction

  // Expected cycle list for one instruction: fetch (fs stalls), decode, then class phases
  // with ms memory stalls.
  task automatic model_instr(input int kind, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z, l, lu, input int fs, ms);
    cyc_t c;
    logic [2:0] im;
    logic [19:0] wb;
    c.op = op; c.f3 = f3; c.f7 = f7; c.z = z; c.l = l; c.lu = lu; c.mr = 1'b1; c.exp = '0;
    im = imm_of(op);
    wb = pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, im, 4'd0, 1, 0);
    for (int i = 0; i < fs; i++) exp_q.push_back(mkc(c, 1'b0, pk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, im, 4'd0, 0, 0)));
    exp_q.push_back(mkc(c, 1'b1, pk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, im, 4'd0, 0, 0)));
    exp_q.push_back(mkc(c, 1'($urandom_range(0, 1)), pk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, im, 4'd0, 0, 0)));
    case (kind)
      K_LOAD, K_STORE: begin
        exp_q.push_back(mkc(c, 1'($urandom_range(0, 1)), pk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, im, 4'd0, 0, 0)));
        for (int i = 0; i <= ms; i++)
          exp_q.push_back(mkc(c, (i == ms), pk(0, 1, (kind == K_STORE), 0, 0, 2'd0, 2'd0, 2'd0, im, 4'd0,
                                               (kind == K_STORE && i == ms), 0)));
        if (kind == K_LOAD)
          exp_q.push_back(mkc(c, 1'($urandom_range(0, 1)), pk(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, im, 4'd0, 1, 0)));
      end
      K_R, K_I: begin
        exp_q.push_back(mkc(c, 1'($urandom_range(0, 1)), pk(0, 0, 0, 0, 0, 2'd0, 2'd2, (kind == K_I) ? 2'd1 : 2'd0,
                                                          im, alu_exp(kind == K_R, f3, f7[5]), 0, 0)));
        exp_q.push_back(mkc(c, 1'($urandom_range(0, 1)), wb));
      end
      K_BR:
        exp_q.push_back(mkc(c, 1'($urandom_range(0, 1)), pk(taken_of(f3, z, l, lu), 0, 0, 0, 0, 2'd0, 2'd2, 2'd0,
                                                          im, 4'd1, 1, 0)));
      K_JAL: begin
        exp_q.push_back(mkc(c, 1'($urandom_range(0, 1)), pk(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, im, 4'd0, 0, 0)));
        exp_q.push_back(mkc(c, 1'($urandom_range(0, 1)), wb));
      end
      default: begin
        exp_q.push_back(mkc(c, 1'($urandom_range(0, 1)), pk(0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd1, im, 4'd0, 0, 0)));
        exp_q.push_back(mkc(c, 1'($urandom_range(0, 1)), wb));
      end
    endcase
  endtask

  // Applies one cycle of inputs just after a rising edge and samples at the falling edge.
  task automatic step(input cyc_t c, output logic [19:0] o, output logic [19:0] o2);
    mem_ready = c.mr; op_code = c.op; funct3 = c.f3; funct7 = c.f7;
    zero = c.z; lt = c.l; ltu = c.lu;
    @(negedge clk);
    o = obs_vec;
    o2 = obs2_vec;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] o, o2;
    cyc_t c;
    rst_n = 1'b0; mem_ready = 1'b1; op_code = 7'b0110011;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (obs_vec !== pk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 4'd0, 0, 0))
      $display("FAIL reset_hold: got %05h expected %05h", obs_vec, pk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 4'd0, 0, 0));
    else passes++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_instr(K_R, 7'b0110011, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    c = exp_q.pop_front();
    step(c, o, o2);
    checks++;
    if (o !== c.exp) $display("FAIL reset_first_fetch: got %05h expected %05h", o, c.exp);
    else passes++;
    exp_q.delete();
  endtask

  task automatic test_add();
    logic [19:0] o, o2;
    cyc_t c;
    int n = 0, rw = 0, rt = 0;
    do_reset();
    model_instr(K_R, 7'b0110011, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      step(c, o, o2);
      checks++;
      if (o !== c.exp) $display("FAIL add cycle %0d: got %05h expected %05h", n, o, c.exp);
      else passes++;
      rw += (o[15] === 1'b1 && n == 3) ? 1 : 0;
      rt += (o[1] === 1'b1) ? 1 : 0;
      n++;
    end
    checks++;
    if (rw != 1 || rt != 1) $display("FAIL add_writes: got reg_w@4=%0d retires=%0d expected 1 1", rw, rt);
    else passes++;
  endtask

  task automatic test_load_stall();
    logic [19:0] o, o2;
    cyc_t c;
    int n = 0, rw = 0;
    model_instr(K_LOAD, 7'b0000011, 3'd2, 7'd0, 0, 0, 0, 0, 3);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      step(c, o, o2);
      checks++;
      if (o !== c.exp) $display("FAIL lw_stall cycle %0d: got %05h expected %05h", n, o, c.exp);
      else passes++;
      rw += (o[15] === 1'b1) ? ((n == 7) ? 1 : 100) : 0;
      n++;
    end
    checks++;
    if (rw != 1) $display("FAIL lw_reg_w: got code %0d expected 1 (single write in cycle 8)", rw);
    else passes++;
  endtask

  task automatic test_branch();
    logic [19:0] o, o2;
    cyc_t c;
    int n = 0;
    model_instr(K_BR, 7'b1100011, 3'b001, 7'd0, 1, 0, 0, 0, 0);
    model_instr(K_BR, 7'b1100011, 3'b001, 7'd0, 0, 0, 0, 1, 0);
    model_instr(K_BR, 7'b1100011, 3'b110, 7'd0, 0, 0, 1, 0, 0);
    model_instr(K_BR, 7'b1100011, 3'b110, 7'd0, 1, 1, 0, 0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      step(c, o, o2);
      checks++;
      if (o !== c.exp) $display("FAIL branch cycle %0d: got %05h expected %05h", n, o, c.exp);
      else passes++;
      n++;
    end
  endtask

  task automatic test_trap();
    logic [19:0] o, o2;
    cyc_t c;
    logic [19:0] tv;
    tv = pk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0, 1);
    for (int t = 0; t < 2; t++) begin
      do_reset();
      c.op = (t == 0) ? 7'b1110011 : 7'b1100011;
      c.f3 = (t == 0) ? 3'd0 : 3'b010;
      c.f7 = '0; c.z = 1'b1; c.l = 1'b1; c.lu = 1'b1; c.mr = 1'b1; c.exp = '0;
      exp_q.push_back(mkc(c, 1'b1, pk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, imm_of(c.op), 4'd0, 0, 0)));
      exp_q.push_back(mkc(c, 1'b1, pk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, imm_of(c.op), 4'd0, 0, 0)));
      for (int i = 0; i < 6; i++) exp_q.push_back(mkc(c, 1'($urandom_range(0, 1)), tv));
      for (int n = 0; exp_q.size() > 0; n++) begin
        c = exp_q.pop_front();
        step(c, o, o2);
        checks++;
        if (o !== c.exp) $display("FAIL trap%0d cycle %0d: got %05h expected %05h", t, n, o, c.exp);
        else passes++;
      end
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (illegal !== 1'b0) $display("FAIL trap_clear: got illegal=%b expected 0", illegal);
    else passes++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset_midwrite();
    logic [19:0] o, o2;
    cyc_t c;
    do_reset();
    model_instr(K_STORE, 7'b0100011, 3'd2, 7'd0, 0, 0, 0, 0, 5);
    for (int n = 0; n < 4; n++) begin
      c = exp_q.pop_front();
      step(c, o, o2);
      checks++;
      if (o !== c.exp) $display("FAIL sw_pre_reset cycle %0d: got %05h expected %05h", n, o, c.exp);
      else passes++;
    end
    exp_q.delete();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_w !== 1'b1) $display("FAIL sw_mem_w_before: got %b expected 1", mem_w);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec !== pk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'b001, 4'd0, 0, 0))
      $display("FAIL sw_reset_drop: got %05h expected %05h", obs_vec, pk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'b001, 4'd0, 0, 0));
    else passes++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_instr(K_STORE, 7'b0100011, 3'd2, 7'd0, 0, 0, 0, 0, 0);
    c = exp_q.pop_front();
    step(c, o, o2);
    checks++;
    if (o !== c.exp) $display("FAIL sw_refetch: got %05h expected %05h", o, c.exp);
    else passes++;
    exp_q.delete();
  endtask

  task automatic test_nowait();
    logic [19:0] o, o2;
    logic [19:0] e2 [5];
    cyc_t c;
    do_reset();
    e2[0] = pk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 3'b001, 4'd0, 0, 0);
    e2[1] = pk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'b001, 4'd0, 0, 0);
    e2[2] = pk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'b001, 4'd0, 0, 0);
    e2[3] = pk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'b001, 4'd0, 1, 0);
    e2[4] = e2[0];
    c.op = 7'b0100011; c.f3 = 3'd2; c.f7 = '0; c.z = 0; c.l = 0; c.lu = 0; c.mr = 1'b1; c.exp = '0;
    for (int n = 0; n < 5; n++) begin
      step(c, o, o2);
      checks++;
      if (o2 !== e2[n]) $display("FAIL nowait_sw cycle %0d: got %05h expected %05h", n, o2, e2[n]);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic [19:0] o, o2;
    cyc_t c;
    int kind, rt = 0, n = 0;
    logic [2:0] f3;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 6);
      f3 = 3'($urandom_range(0, 7));
      if (kind == K_BR) f3 = br_tab[$urandom_range(0, 5)];
      model_instr(kind, opc_tab[kind], f3, 7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 3));
    end
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      step(c, o, o2);
      checks++;
      if (o !== c.exp) $display("FAIL random cycle %0d: got %05h expected %05h", n, o, c.exp);
      else passes++;
      rt += (o[1] === 1'b1) ? 1 : 0;
      n++;
    end
    checks++;
    if (rt != 40) $display("FAIL random_retires: got %0d expected 40", rt);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_stall();
    test_branch();
    test_trap();
    test_reset_midwrite();
    test_nowait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 1: 1 = honour mem_ready stalls; 0 = mem_ready ignored, treated as 1.
REQ-002 Parameter ALU_CTRL_W, default 4: alu_control width; values below 4 are illegal (elaboration error).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 op_code  input  7  instruction opcode from instruction register.
REQ-006 funct3  input  3  instruction funct3.
REQ-007 funct7  input  7  instruction funct7; only bit 5 is used.
REQ-008 zero, lt, ltu  input  1 each  ALU flags: result zero, signed less-than, unsigned less-than.
REQ-009 mem_ready  input  1  memory access completes this cycle.
REQ-010 pc_w  output  1  PC write enable.
REQ-011 adr_src  output  1  memory address select: 0 PC, 1 ALU_out.
REQ-012 mem_w, ir_w, reg_w  output  1 each  memory write, instruction register write, register-file write.
REQ-013 result_src  output  2  00 ALU_out, 01 read data, 10 ALU result.
REQ-014 alu_src_a  output  2  00 PC, 01 old PC, 10 rs1, 11 zero.
REQ-015 alu_src_b  output  2  00 rs2, 01 immediate, 10 constant 4.
REQ-016 imm_src  output  3  I 000, S 001, B 010, J 011, U 100.
REQ-017 alu_control  output  ALU_CTRL_W  ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9.
REQ-018 retire  output  1  one-cycle pulse in the final state of each instruction.
REQ-019 illegal  output  1  sticky trap flag.

Function
REQ-020 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, LUI, TRAP.
REQ-021 FETCH: adr_src 0, a=00, b=10, ADD, result_src 10; ir_w and pc_w asserted only when mem_ready; DECODE on mem_ready, else hold.
REQ-022 DECODE: a=01, b=01, ADD (branch target); next by opcode: 0000011/0100011 MEMADR, 0110011 EXEC_R, 0010011 EXEC_I, 1100011 BRANCH, 1101111 JAL, 0110111 LUI, any other opcode TRAP.
REQ-023 BRANCH with funct3 010 or 011 goes to TRAP from DECODE.
REQ-024 MEMADR: a=10, b=01, ADD; opcode 0000011 goes to MEMREAD, else MEMWRITE.
REQ-025 MEMREAD: adr_src 1, result_src 00; hold until mem_ready, then MEMWB.
REQ-026 MEMWB: result_src 01, reg_w 1, retire 1; next FETCH.
REQ-027 MEMWRITE: adr_src 1, mem_w 1 until mem_ready; retire on mem_ready cycle; next FETCH.
REQ-028 EXEC_R: a=10, b=00; EXEC_I: a=10, b=01; both next ALUWB.
REQ-029 ALUWB: result_src 00, reg_w 1, retire 1; next FETCH.
REQ-030 BRANCH: a=10, b=00, SUB, result_src 00; pc_w = taken; retire 1; next FETCH.
REQ-031 Taken: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
REQ-032 JAL: a=01, b=10, ADD, result_src 00, pc_w 1; next ALUWB. LUI: a=11, b=01, ADD; next ALUWB.
REQ-033 ALU decode: R/I use funct3 (000 ADD, or SUB when R and funct7[5]; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7[5]; 110 OR; 111 AND); other states use the fixed op given.
REQ-034 imm_src from opcode: load/I 000, store 001, branch 010, jal 011, lui 100.
REQ-035 TRAP: illegal 1, all enables 0, no exit except reset.
REQ-036 Unlisted outputs are 0 in every state; no two of mem_w, reg_w, ir_w are high together.
REQ-037 Cycles per instruction with zero wait: load 5, store 4, R/I/JAL/LUI 4, branch 3; each mem_ready-low cycle adds one.

Reset
REQ-038 rst_n low forces FETCH asynchronously and clears illegal; pc_w, ir_w, mem_w, reg_w, retire are 0 while rst_n is low.
REQ-039 Reset mid-instruction abandons it with no further write; first FETCH follows rst_n release.

Structure
REQ-040 Package mc_pkg holds the state enum, opcode constants, alu_control encodings, imm_src encodings and mux-select encodings.
REQ-041 One combinational sub-module mc_alu_dec computes alu_control from state class, funct3 and funct7[5].

Verification
REQ-042 add x3,x1,x2 (0110011, f3 000, f7 0), mem_ready 1 -> FETCH-DECODE-EXEC_R-ALUWB, alu_control 0, reg_w in cycle 4, retire once.
REQ-043 lw with mem_ready low 3 cycles in MEMREAD -> 8 cycles total, reg_w only in MEMWB.
REQ-044 bne with zero=1 -> pc_w 0 in BRANCH; with zero=0 -> pc_w 1; bltu with ltu=1 -> pc_w 1.
REQ-045 Opcode 1110011 -> TRAP after DECODE, illegal sticky, no enables, cleared only by rst_n.
REQ-046 rst_n low during MEMWRITE with mem_w high -> mem_w drops immediately, FETCH after release.
REQ-047 MEM_WAIT=0 with mem_ready tied 0 -> sw completes in 4 cycles.
